// File: rtl/axis_image_frame_gen.sv
// AXI-Stream test-pattern source: emits num_frames frames of width x height pixels, one per beat.
// First beat one cycle after an accepted start; counters and outputs hold while ready is low.
module axis_image_frame_gen #(
  parameter int DATA_BYTES = 4,
  parameter int DIM_BITS   = 12,
  parameter int FRAME_BITS = 8,
  localparam int DATA_BITS = DATA_BYTES * 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DIM_BITS-1:0]   width_i,
  input  logic [DIM_BITS-1:0]   height_i,
  input  logic [FRAME_BITS-1:0] num_frames_i,
  input  logic [1:0]            mode_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_BITS-1:0]  axis_m_data_o,
  output logic                  axis_m_valid_o,
  input  logic                  axis_m_ready_i,
  output logic                  axis_m_last_o,
  output logic                  axis_m_user_o
);

  localparam int PIX_BITS = 2 * DIM_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DIM_BITS-1:0]   x_q, x_d, y_q, y_d;
  logic [DIM_BITS-1:0]   w_q, w_d, h_q, h_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d, nf_q, nf_d;
  logic [PIX_BITS-1:0]   pix_q, pix_d;
  logic [1:0]            mode_q, mode_d;

  logic run, acc, last_x, last_y, last_f;

  assign run    = (state_q == S_RUN);
  assign acc    = run && axis_m_ready_i;
  assign last_x = (x_q == w_q - DIM_BITS'(1));
  assign last_y = (y_q == h_q - DIM_BITS'(1));
  assign last_f = (frame_q == nf_q - FRAME_BITS'(1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    pix_d   = pix_q;
    w_d     = w_q;
    h_d     = h_q;
    nf_d    = nf_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          w_d     = width_i;
          h_d     = height_i;
          nf_d    = num_frames_i;
          mode_d  = mode_i;
          x_d     = '0;
          y_d     = '0;
          frame_d = '0;
          pix_d   = '0;
          // A zero dimension or frame count completes without emitting a beat.
          if (width_i == '0 || height_i == '0 || num_frames_i == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (acc) begin
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d   = '0;
              pix_d = '0;
              if (last_f) begin
                state_d = S_FIN;
              end else begin
                frame_d = frame_q + FRAME_BITS'(1);
              end
            end else begin
              y_d   = y_q + DIM_BITS'(1);
              pix_d = pix_q + PIX_BITS'(1);
            end
          end else begin
            x_d   = x_q + DIM_BITS'(1);
            pix_d = pix_q + PIX_BITS'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      pix_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      nf_q    <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      pix_q   <= pix_d;
      w_q     <= w_d;
      h_q     <= h_d;
      nf_q    <= nf_d;
      mode_q  <= mode_d;
    end
  end

  logic [DATA_BITS-1:0] pat;

  always_comb begin
    pat = '0;
    case (mode_q)
      2'd0:    pat = DATA_BITS'(pix_q);
      2'd1:    pat = DATA_BITS'(frame_q);
      2'd2:    pat = {DATA_BITS{x_q[3] ^ y_q[3]}};
      default: pat = DATA_BITS'({y_q, x_q});
    endcase
  end

  // Outputs are pure functions of registered state, so reset clears them at once.
  assign busy_o         = run;
  assign done_o         = (state_q == S_FIN);
  assign axis_m_valid_o = run;
  assign axis_m_data_o  = run ? pat : '0;
  assign axis_m_last_o  = run && last_x;
  assign axis_m_user_o  = run && (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_axis_image_frame_gen.sv
// Directed bench for axis_image_frame_gen with hand-derived expected beats.
module tb_axis_image_frame_gen;

  logic        clk;
  logic        rstn;
  logic [11:0] width_i, height_i;
  logic [7:0]  num_frames_i;
  logic [1:0]  mode_i;
  logic        start_i;
  logic        busy_o, done_o;
  logic [31:0] data_o;
  logic        valid_o, ready_i, last_o, user_o;

  int checks = 0;
  int errors = 0;

  axis_image_frame_gen dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .width_i       (width_i),
    .height_i      (height_i),
    .num_frames_i  (num_frames_i),
    .mode_i        (mode_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .axis_m_data_o (data_o),
    .axis_m_valid_o(valid_o),
    .axis_m_ready_i(ready_i),
    .axis_m_last_o (last_o),
    .axis_m_user_o (user_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input int mode, input int x, input int y,
                                        input int f, input int w);
    logic [11:0] xv, yv;
    xv = 12'(x);
    yv = 12'(y);
    case (mode)
      0:       return 32'(y * w + x);
      1:       return 32'(f);
      2:       return (xv[3] ^ yv[3]) ? 32'hFFFF_FFFF : 32'h0;
      default: return {8'h0, yv, xv};
    endcase
  endfunction

  task automatic start_run(input int w, input int h, input int f, input int m);
    @(negedge clk);
    width_i      = 12'(w);
    height_i     = 12'(h);
    num_frames_i = 8'(f);
    mode_i       = 2'(m);
    start_i      = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_o, busy_o, done_o, last_o, user_o} !== 5'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b l=%b u=%b data=%h, want all 0",
               valid_o, busy_o, done_o, last_o, user_o, data_o);
    end
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_basic;
    ready_i = 1'b1;
    start_run(4, 2, 2, 0);
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || busy_o !== 1'b1 || data_o !== 32'(b % 8) ||
          last_o !== (b % 4 == 3) || user_o !== (b % 8 == 0)) begin
        errors++;
        $display("FAIL basic_beat%0d: got v=%b b=%b data=%0d l=%b u=%b, want v=1 b=1 data=%0d l=%b u=%b",
                 b, valid_o, busy_o, data_o, last_o, user_o, b % 8, (b % 4 == 3), (b % 8 == 0));
      end
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got v=%b d=%b b=%b, want v=0 d=1 b=0", valid_o, done_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b, want 0", done_o);
    end
  endtask

  task automatic test_stall;
    int          idx = 0;
    int          c = 0;
    bit          prev_stall = 0;
    logic [31:0] pd;
    logic        pl, pu, r;
    start_run(4, 2, 2, 0);
    while (idx < 16 && c < 200) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (data_o !== pd || last_o !== pl || user_o !== pu) begin
          errors++;
          $display("FAIL stall_hold c%0d: got data=%h l=%b u=%b, want data=%h l=%b u=%b",
                   c, data_o, last_o, user_o, pd, pl, pu);
        end
      end
      checks++;
      if (valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_valid c%0d: got valid=%b, want 1", c, valid_o);
      end
      r = (c % 4 == 0) || (c % 4 == 3);
      ready_i = r;
      if (r) begin
        checks++;
        if (data_o !== 32'(idx % 8) || last_o !== (idx % 4 == 3) || user_o !== (idx % 8 == 0)) begin
          errors++;
          $display("FAIL stall_beat%0d: got data=%0d l=%b u=%b, want data=%0d l=%b u=%b",
                   idx, data_o, last_o, user_o, idx % 8, (idx % 4 == 3), (idx % 8 == 0));
        end
        idx++;
      end
      prev_stall = !r;
      pd = data_o;
      pl = last_o;
      pu = user_o;
      c++;
    end
    checks++;
    if (idx != 16) begin
      errors++;
      $display("FAIL stall_timeout: got %0d beats, want 16", idx);
    end
    @(negedge clk);
    ready_i = 1'b1;
    checks++;
    if (valid_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got v=%b d=%b, want v=0 d=1", valid_o, done_o);
    end
  endtask

  task automatic test_checker;
    int nb = 0;
    int nl = 0;
    int c = 0;
    ready_i = 1'b1;
    start_run(20, 16, 1, 2);
    while (!done_o && c < 400) begin
      @(negedge clk);
      if (valid_o) begin
        checks++;
        if (data_o !== model(2, nb % 20, nb / 20, 0, 20)) begin
          errors++;
          $display("FAIL checker_x%0d_y%0d: got %h, want %h",
                   nb % 20, nb / 20, data_o, model(2, nb % 20, nb / 20, 0, 20));
        end
        if (last_o) nl++;
        nb++;
      end
      c++;
    end
    checks++;
    if (nb != 320 || nl != 16) begin
      errors++;
      $display("FAIL checker_counts: got beats=%0d lasts=%0d, want 320 and 16", nb, nl);
    end
  endtask

  task automatic test_zero_config;
    int ndone;
    for (int k = 0; k < 2; k++) begin
      ndone = 0;
      start_run(k == 0 ? 0 : 4, 2, k == 0 ? 2 : 0, 0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (c == 0) begin
          checks++;
          if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL zero%0d_done_time: got done=%b, want 1", k, done_o);
          end
        end
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL zero%0d_novalid c%0d: got v=%b b=%b, want 0 0", k, c, valid_o, busy_o);
        end
        if (done_o) ndone++;
      end
      checks++;
      if (ndone != 1) begin
        errors++;
        $display("FAIL zero%0d_done_count: got %0d, want 1", k, ndone);
      end
    end
  endtask

  task automatic test_restart_ignored;
    int nb = 0;
    int ndone = 0;
    ready_i = 1'b1;
    start_run(3, 2, 1, 3);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i = 1'b1;
        width_i = 12'd5;
      end
      if (c == 2) start_i = 1'b0;
      if (valid_o) begin
        checks++;
        if (data_o !== model(3, nb % 3, nb / 3, 0, 3)) begin
          errors++;
          $display("FAIL restart_beat%0d: got %h, want %h", nb, data_o, model(3, nb % 3, nb / 3, 0, 3));
        end
        nb++;
      end
      if (done_o) ndone++;
    end
    checks++;
    if (nb != 6 || ndone != 1) begin
      errors++;
      $display("FAIL restart_counts: got beats=%0d dones=%0d, want 6 and 1", nb, ndone);
    end
  endtask

  task automatic test_async_reset;
    ready_i = 1'b1;
    start_run(4, 4, 1, 0);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({valid_o, busy_o, done_o, last_o, user_o} !== 5'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got v=%b b=%b d=%b l=%b u=%b data=%h, want all 0",
               valid_o, busy_o, done_o, last_o, user_o, data_o);
    end
    @(negedge clk) rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle c%0d: got v=%b b=%b, want 0 0", c, valid_o, busy_o);
      end
    end
    start_run(1, 1, 3, 1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'(b) || last_o !== 1'b1 || user_o !== 1'b1) begin
        errors++;
        $display("FAIL tiny_beat%0d: got v=%b data=%0d l=%b u=%b, want v=1 data=%0d l=1 u=1",
                 b, valid_o, data_o, last_o, user_o, b);
      end
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL tiny_done: got v=%b d=%b, want v=0 d=1", valid_o, done_o);
    end
  endtask

  initial begin
    width_i      = '0;
    height_i     = '0;
    num_frames_i = '0;
    mode_i       = '0;
    start_i      = 1'b0;
    ready_i      = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_checker();
    test_zero_config();
    test_restart_ignored();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
